// File: rtl/window_reader_pkg.sv
// Shared definitions for window_reader: FSM state encoding, output FIFO sizing
// and the FIFO pointer increment helper.
package window_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FIFO_OCC_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [FIFO_PTR_W-1:0] fifo_ptr_inc(input logic [FIFO_PTR_W-1:0] p);
        return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/window_fifo.sv
// Small valid/ready FIFO holding complete windows (three words packed together).
// Read data comes straight from storage, so it stays put while the head is stalled.
module window_fifo
    import window_reader_pkg::*;
#(
    parameter int unsigned DW = 96
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [FIFO_OCC_W-1:0] occupancy
);

    logic [DW-1:0]         mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic [FIFO_OCC_W-1:0] occ;
    logic                  push;
    logic                  pop;

    assign pop  = out_valid && out_ready;
    assign push = in_valid && ((occ != FIFO_OCC_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= fifo_ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= fifo_ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + FIFO_OCC_W'(1);
                2'b01:   occ <= occ - FIFO_OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];
    assign occupancy = occ;

endmodule

// File: rtl/window_reader.sv
// Issues three-word sliding-window reads to a RAM and streams the windows out.
// Optional feature: define WINDOW_READER_STALL_CNT_EN to enable the stall_cycles counter.
module window_reader
    import window_reader_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   raddr_0,
    output logic [ADDR_WIDTH:0]   raddr_1,
    output logic [ADDR_WIDTH:0]   raddr_2,
    input  logic [WIDTH-1:0]      rdata_0,
    input  logic [WIDTH-1:0]      rdata_1,
    input  logic [WIDTH-1:0]      rdata_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data_0,
    output logic [WIDTH-1:0]      out_data_1,
    output logic [WIDTH-1:0]      out_data_2,
    output logic [15:0]           stall_cycles
);

    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_A   = (ADDR_WIDTH + 1)'(1);

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic                    inflight_q;
    logic                    done_q;
    logic                    accept_start;
    logic                    zero_job;
    logic                    issue;
    logic                    last_issue;
    logic                    last_accept;
    logic                    pop;
    logic [FIFO_OCC_W-1:0]   occ;
    logic [FIFO_OCC_W:0]     slots_used;
    logic [3*WIDTH-1:0]      fifo_data;

    function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                       input logic [1:0]            k);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, a} + (ADDR_WIDTH + 1)'(k);
        if (s >= DEPTH_A) begin
            s = s - DEPTH_A;
        end
        return s[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] mod_depth(input logic [ADDR_WIDTH:0] a);
        logic [ADDR_WIDTH:0] r;
        r = a % DEPTH_A;
        return r[ADDR_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start && (count != '0)) next_state = RUN;
            RUN:     if (last_issue)             next_state = DRAIN;
            DRAIN:   if (last_accept)            next_state = IDLE;
            default:                             next_state = IDLE;
        endcase
    end

    // A read may issue only while the FIFO entries plus the read still in flight,
    // after this cycle's pop, leave a free slot for the returning data.
    always_comb begin
        pop          = out_valid && out_ready;
        slots_used   = (FIFO_OCC_W + 1)'(occ) + (FIFO_OCC_W + 1)'(inflight_q)
                     - (FIFO_OCC_W + 1)'(pop);
        busy         = (state != IDLE);
        accept_start = (state == IDLE) && start;
        zero_job     = accept_start && (count == '0);
        issue        = (state == RUN) && (slots_used < (FIFO_OCC_W + 1)'(FIFO_DEPTH));
        last_issue   = issue && ((issued_q + ONE_A) == count_q);
        last_accept  = (state == DRAIN) && pop && !inflight_q
                     && (occ == FIFO_OCC_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            raddr_0    <= '0;
            raddr_1    <= '0;
            raddr_2    <= '0;
        end else begin
            done_q     <= zero_job || last_accept;
            inflight_q <= issue;
            if (accept_start) begin
                addr_q   <= mod_depth(base_addr);
                count_q  <= count;
                issued_q <= '0;
            end else if (issue) begin
                raddr_0  <= {1'b0, addr_q};
                raddr_1  <= {1'b0, wrap_add(addr_q, 2'd1)};
                raddr_2  <= {1'b0, wrap_add(addr_q, 2'd2)};
                addr_q   <= wrap_add(addr_q, 2'd1);
                issued_q <= issued_q + ONE_A;
            end
        end
    end

    assign done = done_q;

    window_fifo #(
        .DW (3 * WIDTH)
    ) u_window_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_q),
        .in_data   ({rdata_2, rdata_1, rdata_0}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_data),
        .occupancy (occ)
    );

    assign out_data_0 = fifo_data[WIDTH-1:0];
    assign out_data_1 = fifo_data[2*WIDTH-1:WIDTH];
    assign out_data_2 = fifo_data[3*WIDTH-1:2*WIDTH];

`ifdef WINDOW_READER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (accept_start) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_window_reader.sv
// Directed self-checking bench for window_reader (DEPTH=16, RAM word[n]=n).
module tb_window_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
`ifdef WINDOW_READER_STALL_CNT_EN
    localparam int unsigned STALL_EXP = 8;
`else
    localparam int unsigned STALL_EXP = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW:0]      base_addr;
    logic [AW:0]      count;
    logic             busy;
    logic             done;
    logic [AW:0]      raddr_0, raddr_1, raddr_2;
    logic [WIDTH-1:0] rdata_0, rdata_1, rdata_2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data_0, out_data_1, out_data_2;
    logic [15:0]      stall_cycles;

    logic [WIDTH-1:0] mem [DEPTH];
    int unsigned      errors = 0;
    int unsigned      checks = 0;
    int unsigned      exp14 [9] = '{14, 15, 0, 15, 0, 1, 0, 1, 2};

    always #5 clk = ~clk;

    assign rdata_0 = mem[raddr_0[AW-1:0]];
    assign rdata_1 = mem[raddr_1[AW-1:0]];
    assign rdata_2 = mem[raddr_2[AW-1:0]];

    window_reader #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .raddr_0      (raddr_0),
        .raddr_1      (raddr_1),
        .raddr_2      (raddr_2),
        .rdata_0      (rdata_0),
        .rdata_1      (rdata_1),
        .rdata_2      (rdata_2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data_0   (out_data_0),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_window(input string tag, input int unsigned a0, input int unsigned a1,
                                input int unsigned a2);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_d0"}, out_data_0, a0);
        check({tag, "_d1"}, out_data_1, a1);
        check({tag, "_d2"}, out_data_2, a2);
    endtask

    task automatic launch(input int unsigned b, input int unsigned n);
        start     = 1'b1;
        base_addr = (AW + 1)'(b);
        count     = (AW + 1)'(n);
        tick();
        start     = 1'b0;
    endtask

    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = i;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_raddr0", 32'(raddr_0), 32'd0);
        check("rst_raddr2", 32'(raddr_2), 32'd0);
        check("rst_data0", out_data_0, 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        rst = 1'b0;
        tick();

        // base=2, count=4, ready held high
        launch(2, 4);
        check("A_c0_busy", 32'(busy), 32'd1);
        check("A_c0_valid", 32'(out_valid), 32'd0);
        tick();
        check("A_c1_valid", 32'(out_valid), 32'd0);
        check("A_c1_raddr0", 32'(raddr_0), 32'd2);
        check("A_c1_raddr1", 32'(raddr_1), 32'd3);
        check("A_c1_raddr2", 32'(raddr_2), 32'd4);
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check_window("A_win", 2 + i, 3 + i, 4 + i);
            check("A_done_early", 32'(done), 32'd0);
        end
        tick();
        check("A_done", 32'(done), 32'd1);
        check("A_busy_end", 32'(busy), 32'd0);
        check("A_valid_end", 32'(out_valid), 32'd0);
        check("A_raddr0_hold", 32'(raddr_0), 32'd5);
        check("A_raddr2_hold", 32'(raddr_2), 32'd7);
        tick();
        check("A_done_pulse", 32'(done), 32'd0);

        // wrap: base=14, count=3
        launch(14, 3);
        tick();
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_window("B_win", exp14[3*i], exp14[3*i+1], exp14[3*i+2]);
        end
        tick();
        check("B_done", 32'(done), 32'd1);

        // count=5 with out_ready pattern 1,0,0,1,0,0,... from first valid cycle
        launch(0, 5);
        for (int unsigned c = 0; c < 15; c++) begin
            out_ready = (c < 2) || (((c - 2) % 3) == 0);
            check("C_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check("C_d0", out_data_0, c / 3);
                check("C_d1", out_data_1, c / 3 + 1);
                check("C_d2", out_data_2, c / 3 + 2);
            end
            check("C_done_early", 32'(done), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        check("C_done", 32'(done), 32'd1);
        check("C_busy_end", 32'(busy), 32'd0);
        check("C_stall", 32'(stall_cycles), STALL_EXP);

        // count=0
        launch(5, 0);
        check("D_done", 32'(done), 32'd1);
        check("D_busy", 32'(busy), 32'd0);
        check("D_valid", 32'(out_valid), 32'd0);
        check("D_stall_clr", 32'(stall_cycles), 32'd0);
        tick();
        check("D_done_pulse", 32'(done), 32'd0);
        check("D_valid2", 32'(out_valid), 32'd0);

        // reset after the second of six windows
        launch(0, 6);
        tick();
        tick();
        check_window("E_w0", 0, 1, 2);
        tick();
        check_window("E_w1", 1, 2, 3);
        tick();
        rst = 1'b1;
        #1;
        check("E_rst_valid", 32'(out_valid), 32'd0);
        check("E_rst_busy", 32'(busy), 32'd0);
        check("E_rst_raddr0", 32'(raddr_0), 32'd0);
        check("E_rst_data0", out_data_0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check("E_no_done", 32'(done), 32'd0);
            check("E_idle_valid", 32'(out_valid), 32'd0);
        end
        launch(0, 2);
        tick();
        tick();
        check_window("E_new0", 0, 1, 2);
        tick();
        check_window("E_new1", 1, 2, 3);
        tick();
        check("E_new_done", 32'(done), 32'd1);
        tick();

        // start held high during a count=8 job
        launch(3, 8);
        start     = 1'b1;
        base_addr = 5'd9;
        count     = 5'd2;
        for (int unsigned c = 1; c < 10; c++) begin
            tick();
            if (c == 9) start = 1'b0;
            if (c >= 2) check_window("F_win", 3 + c - 2, 4 + c - 2, 5 + c - 2);
            check("F_done_early", 32'(done), 32'd0);
        end
        tick();
        check("F_done", 32'(done), 32'd1);
        check("F_busy_end", 32'(busy), 32'd0);
        tick();
        check("F_done_once", 32'(done), 32'd0);
        check("F_idle_busy", 32'(busy), 32'd0);
        check("F_idle_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
